// File: rtl/exp_scan_pkg.sv
// Shared types for the exponent scan controller: modular-multiplier command
// encoding and the controller state encoding.
package exp_scan_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'b00,
    SQUARE   = 2'b01,
    MULTIPLY = 2'b10,
    ONE      = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SCAN  = 3'd2,
    ISSUE = 3'd3,
    WAIT  = 3'd4,
    NEXT  = 3'd5,
    FIN   = 3'd6
  } state_e;

endpackage

// File: rtl/exp_scan_ctrl_if.sv
// Bundle of the controller's start, shift-register and multiplier-command signals.
// The master side is the scan controller; the slave side is its environment.
interface exp_scan_ctrl_if #(
  parameter int WIDTH = 256
);

  logic             start;
  logic [WIDTH-1:0] exponent;
  logic             busy;
  logic             done;
  logic             sr_enable;
  logic             sr_load;
  logic             sr_dir;
  logic             sr_shift_in;
  logic [WIDTH-1:0] sr_data_in;
  logic             sr_shift_out;
  logic             op_valid;
  logic [1:0]       op_type;
  logic             op_ready;
  logic             op_done;

  modport master (
    input  start, exponent, sr_shift_out, op_ready, op_done,
    output busy, done, sr_enable, sr_load, sr_dir, sr_shift_in, sr_data_in,
           op_valid, op_type
  );

  modport slave (
    output start, exponent, sr_shift_out, op_ready, op_done,
    input  busy, done, sr_enable, sr_load, sr_dir, sr_shift_in, sr_data_in,
           op_valid, op_type
  );

endinterface

// File: rtl/exp_scan_ctrl.sv
// Left-to-right square-and-multiply sequencer: walks the exponent MSB-first through an
// external shift register and issues INIT/SQUARE/MULTIPLY/ONE commands to a multiplier.
module exp_scan_ctrl
  import exp_scan_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] exponent,
  output logic             busy,
  output logic             done,
  output logic             sr_enable,
  output logic             sr_load,
  output logic             sr_dir,
  output logic             sr_shift_in,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic             sr_shift_out,
  output logic             op_valid,
  output logic [1:0]       op_type,
  input  logic             op_ready,
  input  logic             op_done
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  op_e              op_q;
  op_e              op_type_q;
  logic             busy_q;
  logic             done_q;
  logic             sr_en_q;
  logic             sr_load_q;
  logic             op_valid_q;
  logic [WIDTH-1:0] sr_data_q;
  logic             scan_shift;

  // The leading-zero skip must react to the bit visible this cycle, so it is
  // the only shift request not taken from a register.
  assign scan_shift  = (state_q == SCAN) && !sr_shift_out && (cnt_q > CNT_ONE);

  assign sr_enable   = sr_en_q | scan_shift;
  assign sr_load     = sr_load_q;
  assign sr_data_in  = sr_data_q;
  assign sr_dir      = 1'b1;
  assign sr_shift_in = 1'b0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign op_valid    = op_valid_q;
  assign op_type     = op_type_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= INIT;
      op_type_q  <= INIT;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sr_en_q    <= 1'b0;
      sr_load_q  <= 1'b0;
      op_valid_q <= 1'b0;
      sr_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q    <= 1'b1;
            sr_en_q   <= 1'b1;
            sr_load_q <= 1'b1;
            sr_data_q <= exponent;
            state_q   <= LOAD;
          end
        end

        LOAD: begin
          cnt_q     <= CNT_FULL;
          sr_en_q   <= 1'b0;
          sr_load_q <= 1'b0;
          sr_data_q <= '0;
          state_q   <= SCAN;
        end

        SCAN: begin
          if (sr_shift_out) begin
            op_q       <= INIT;
            op_type_q  <= INIT;
            op_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end else if (cnt_q > CNT_ONE) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            op_q       <= ONE;
            op_type_q  <= ONE;
            op_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end

        ISSUE: begin
          if (op_ready) begin
            op_valid_q <= 1'b0;
            op_type_q  <= INIT;
            state_q    <= WAIT;
          end
        end

        WAIT: begin
          if (op_done) begin
            unique case (op_q)
              ONE: begin
                done_q  <= 1'b1;
                state_q <= FIN;
              end
              SQUARE: begin
                if (sr_shift_out) begin
                  op_q       <= MULTIPLY;
                  op_type_q  <= MULTIPLY;
                  op_valid_q <= 1'b1;
                  state_q    <= ISSUE;
                end else begin
                  sr_en_q <= 1'b1;
                  state_q <= NEXT;
                end
              end
              default: begin
                sr_en_q <= 1'b1;
                state_q <= NEXT;
              end
            endcase
          end
        end

        NEXT: begin
          // cnt_q counts the bits still in the register, so reaching one here
          // means the bit just consumed was the last.
          sr_en_q <= 1'b0;
          cnt_q   <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            op_q       <= SQUARE;
            op_type_q  <= SQUARE;
            op_valid_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end

        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/exp_scan_ctrl.md
EXP_SCAN_CTRL -- requirements
Module: exp_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 256: exponent width in bits, minimum 2.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1): width of the bit counter.
REQ-003 SHALL have port clock, input, 1: single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request to begin a scan of exponent; sampled only in IDLE.
REQ-006 SHALL have port exponent, input, WIDTH: exponent value, captured on start.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when the sequence completes.
REQ-009 SHALL have ports sr_enable, sr_load, sr_dir, sr_shift_in, outputs, 1 each: control for the external bidirectional shift register.
REQ-010 SHALL have port sr_data_in, output, WIDTH: load value for the shift register.
REQ-011 SHALL have port sr_shift_out, input, 1: current MSB from the shift register (left mode).
REQ-012 SHALL have ports op_valid, output, 1, and op_type, output, 2: modular-multiplier command, encoded INIT=00 (result<=base), SQUARE=01, MULTIPLY=10, ONE=11 (result<=1).
REQ-013 SHALL have ports op_ready, input, 1 (command accepted) and op_done, input, 1 (one-cycle pulse when the command finishes).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SCAN, ISSUE, WAIT, NEXT, FIN.
REQ-015 IDLE->LOAD on start; in LOAD, drive sr_enable=1, sr_load=1, sr_dir=1, sr_data_in=exponent for exactly one cycle, and set cnt=WIDTH.
REQ-016 SHALL drive sr_dir=1 and sr_shift_in=0 in every state other than IDLE.
REQ-017 SCAN (leading-zero skip): if sr_shift_out=0 and cnt>1, shift once (sr_enable=1, sr_load=0) and decrement cnt each cycle.
REQ-018 SCAN: if sr_shift_out=1, queue INIT and go to ISSUE; if sr_shift_out=0 and cnt=1, queue ONE and go to ISSUE.
REQ-019 ISSUE: hold op_valid=1 with op_type stable until op_ready=1 is sampled, then go to WAIT; op_valid SHALL drop the cycle after the transfer.
REQ-020 WAIT: wait for op_done; op_done in any other state SHALL be ignored.
REQ-021 After INIT or MULTIPLY completes, go to NEXT; after ONE completes, go to FIN.
REQ-022 NEXT: shift once and decrement cnt; if cnt becomes 0, go to FIN, otherwise queue SQUARE and go to ISSUE.
REQ-023 After SQUARE completes: if sr_shift_out=1, queue MULTIPLY; otherwise go to NEXT.
REQ-024 FIN: pulse done=1 for one cycle, then return to IDLE.
REQ-025 Each remaining bit after the leading one SHALL produce SQUARE, followed by MULTIPLY if the bit is 1, in MSB-first order.
REQ-026 start while busy=1 SHALL be ignored, with no effect on the sequence in progress.
REQ-027 cnt SHALL never underflow; every transition is decided on cnt before it is decremented.
REQ-028 sr_enable SHALL be 0 in every cycle not named in REQ-015, REQ-017 or REQ-022.

Reset
REQ-029 reset=1 SHALL force IDLE and cnt=0 on the next edge, overriding every other condition including mid-sequence.
REQ-030 While reset is held and in IDLE, all outputs SHALL be 0, except sr_dir, which is 1.
REQ-031 SHALL ignore an op_done that arrives after reset from a command issued before reset.

Structure
REQ-032 SHALL place the op_type encoding (typedef enum logic [1:0]) and the FSM state enum in package exp_scan_pkg.
REQ-033 SHALL contain no sub-module; the shift register stays external and is driven only through the sr_* ports.

Verification (WIDTH=8)
REQ-034 exponent=8'b0000_1011, op_ready=1 -> op sequence INIT,SQUARE,SQUARE,MULTIPLY,SQUARE,MULTIPLY; one done pulse; 4 SCAN shifts.
REQ-035 exponent=8'h00 -> 7 SCAN shifts, one ONE command, then done; no INIT, SQUARE or MULTIPLY.
REQ-036 exponent=8'h80 -> INIT followed by 7 SQUARE, no MULTIPLY; exponent=8'h01 -> INIT only.
REQ-037 op_ready held low 5 cycles in ISSUE -> op_valid and op_type stable for all 5 cycles; exactly one transfer; a premature op_done is ignored.
REQ-038 reset during WAIT -> IDLE next cycle with all outputs 0 and sr_dir=1; a stale op_done is ignored; a new start runs exponent=8'h03 as INIT,SQUARE,MULTIPLY.
REQ-039 start pulsed mid-sequence -> no reload; sequence and done timing unchanged.
